slice_byte_packer: RTL and testbench

- Sits directly downstream of set_bit and consumes its per-cycle byte output: up to 8 bytes per cycle, given as a count plus a 64-bit value.
- Buffers the bytes in a byte FIFO and repacks them into 32-bit big-endian words.
- Presents the words on a valid/ready interface for the slice memory writer.
- On slice end it flushes the partial word padded with zeros and reports the slice size in bytes.

---
 rtl/slice_byte_packer_if.sv | 10 +
 rtl/slice_byte_packer.sv | 157 +++++++++++++++
 tb/tb_slice_byte_packer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/slice_byte_packer_if.sv
// Word stream from the byte packer to the slice memory writer:
// 32-bit big-endian words on a valid/ready handshake.
interface slice_byte_packer_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (output out_valid, output out_data, input out_ready);
    modport slave  (input out_valid, input out_data, output out_ready);
endinterface

// File: rtl/slice_byte_packer.sv
// Buffers 0..8 bytes per cycle in a byte FIFO and repacks them into 32-bit big-endian
// words; on slice_end it drains a zero-padded tail word and reports the slice size.
module slice_byte_packer #(
    parameter int DEPTH_BYTES = 64,
    parameter int CNT_W       = 7
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [3:0]           in_enable_byte,
    input  logic [63:0]          in_val,
    input  logic                 slice_end,
    slice_byte_packer_if.master  word_bus,
    output logic                 slice_done,
    output logic [31:0]          slice_size_bytes,
    output logic [CNT_W-1:0]     fill_bytes,
    output logic                 overflow,
    output logic                 protocol_error
);

    localparam int AW = $clog2(DEPTH_BYTES);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_r, state_s;
    logic [7:0]       mem_r [DEPTH_BYTES];
    logic [AW-1:0]    wr_ptr_r, wr_ptr_s;
    logic [AW-1:0]    rd_ptr_r, rd_ptr_s;
    logic [CNT_W-1:0] fill_r, fill_s;
    logic [31:0]      byte_cnt_r, byte_cnt_s;
    logic             out_valid_r, out_valid_s;
    logic [31:0]      out_data_r, out_data_s;
    logic             slice_done_r;
    logic [31:0]      slice_size_r;
    logic             overflow_r, perr_r;

    logic [7:0]       in_bytes_s [8];
    logic [AW-1:0]    rd_addr_s [4];
    logic [AW-1:0]    dist_s [4];
    logic [CNT_W:0]   room_need_s;
    logic             cnt_legal_s, fits_s, wr_ok_s, ovf_s, perr_s, pop_s;
    logic [3:0]       wr_cnt_s;
    logic [2:0]       pop_cnt_s;

    // Unpack the input word so that index k is the k-th byte of the stream.
    always_comb begin
        for (int k = 0; k < 8; k++) begin
            in_bytes_s[k] = in_val[63-8*k -: 8];
        end
    end

    // Write/pop decode; the space check deliberately uses fill before any same-cycle pop.
    always_comb begin
        cnt_legal_s = (in_enable_byte != 4'd0) && (in_enable_byte <= 4'd8);
        room_need_s = {1'b0, fill_r} + (CNT_W+1)'(in_enable_byte);
        fits_s      = (room_need_s <= (CNT_W+1)'(DEPTH_BYTES));
        wr_ok_s     = (state_r != ST_FLUSH) && cnt_legal_s && fits_s;
        ovf_s       = (state_r != ST_FLUSH) && cnt_legal_s && !fits_s;
        perr_s      = (in_enable_byte > 4'd8) ||
                      ((state_r == ST_FLUSH) && (in_enable_byte != 4'd0));
        wr_cnt_s    = wr_ok_s ? in_enable_byte : 4'd0;
        pop_s       = out_valid_r && word_bus.out_ready;
        if (!pop_s) begin
            pop_cnt_s = 3'd0;
        end else if (fill_r >= CNT_W'(3'd4)) begin
            pop_cnt_s = 3'd4;
        end else begin
            pop_cnt_s = fill_r[2:0];
        end
        fill_s     = fill_r + CNT_W'(wr_cnt_s) - CNT_W'(pop_cnt_s);
        wr_ptr_s   = wr_ptr_r + AW'(wr_cnt_s);
        rd_ptr_s   = rd_ptr_r + AW'(pop_cnt_s);
        byte_cnt_s = ((state_r == ST_DONE) ? 32'd0 : byte_cnt_r) + 32'(wr_cnt_s);
    end

    // Slice sequencing: RUN -> FLUSH on slice_end, FLUSH -> DONE once empty, DONE lasts one cycle.
    always_comb begin
        case (state_r)
            ST_RUN:   state_s = slice_end ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_s = (fill_s == CNT_W'(1'b0)) ? ST_DONE : ST_FLUSH;
            ST_DONE:  state_s = ST_RUN;
            default:  state_s = ST_RUN;
        endcase
    end

    // Next head word, looking through to bytes being written this cycle; slots past the fill are zero padding.
    always_comb begin
        out_data_s = 32'd0;
        for (int j = 0; j < 4; j++) begin
            rd_addr_s[j] = rd_ptr_s + AW'(j);
            dist_s[j]    = rd_addr_s[j] - wr_ptr_r;
            if (CNT_W'(j) >= fill_s) begin
                out_data_s[31-8*j -: 8] = 8'h00;
            end else if (dist_s[j] < AW'(wr_cnt_s)) begin
                out_data_s[31-8*j -: 8] = in_bytes_s[dist_s[j][2:0]];
            end else begin
                out_data_s[31-8*j -: 8] = mem_r[rd_addr_s[j]];
            end
        end
        out_valid_s = (fill_s >= CNT_W'(3'd4)) ||
                      ((state_s == ST_FLUSH) && (fill_s != CNT_W'(1'b0)));
    end

    // Byte storage: lanes 0..n-1 land at consecutive write addresses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH_BYTES; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (4'(k) < wr_cnt_s) begin
                    mem_r[wr_ptr_r + AW'(k)] <= in_bytes_s[k];
                end
            end
        end
    end

    // Control state, pointers, counters and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_RUN;
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fill_r       <= '0;
            byte_cnt_r   <= 32'd0;
            out_valid_r  <= 1'b0;
            out_data_r   <= 32'd0;
            slice_done_r <= 1'b0;
            slice_size_r <= 32'd0;
            overflow_r   <= 1'b0;
            perr_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            fill_r       <= fill_s;
            byte_cnt_r   <= byte_cnt_s;
            out_valid_r  <= out_valid_s;
            out_data_r   <= out_data_s;
            slice_done_r <= (state_s == ST_DONE);
            slice_size_r <= (state_s == ST_DONE) ? byte_cnt_s : slice_size_r;
            overflow_r   <= overflow_r | ovf_s;
            perr_r       <= perr_r | perr_s;
        end
    end

    assign word_bus.out_valid = out_valid_r;
    assign word_bus.out_data  = out_data_r;
    assign slice_done         = slice_done_r;
    assign slice_size_bytes   = slice_size_r;
    assign fill_bytes         = fill_r;
    assign overflow           = overflow_r;
    assign protocol_error     = perr_r;

endmodule

// File: tb/tb_slice_byte_packer.sv
// Self-checking bench for slice_byte_packer: fixed vector table, hand-written corner
// sequences, and randomized traffic against a byte-queue reference model.
module tb_slice_byte_packer;

    localparam int DEPTH = 64;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  in_enable_byte;
    logic [63:0] in_val;
    logic        slice_end;
    logic        slice_done;
    logic [31:0] slice_size_bytes;
    logic [6:0]  fill_bytes;
    logic        overflow;
    logic        protocol_error;

    slice_byte_packer_if bus ();

    slice_byte_packer #(.DEPTH_BYTES(DEPTH), .CNT_W(7)) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .in_enable_byte   (in_enable_byte),
        .in_val           (in_val),
        .slice_end        (slice_end),
        .word_bus         (bus),
        .slice_done       (slice_done),
        .slice_size_bytes (slice_size_bytes),
        .fill_bytes       (fill_bytes),
        .overflow         (overflow),
        .protocol_error   (protocol_error)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the FIFO is just a queue of bytes in stream order.
    logic [7:0]  mq [$];
    bit          m_flush, m_done, m_ovf, m_perr;
    logic [31:0] m_cnt, m_size;
    logic [31:0] got_words [$];

    typedef struct {
        logic [3:0]  n;
        logic [63:0] val;
        logic        se;
        logic        rdy;
        logic        v;
        logic [31:0] d;
        logic [6:0]  f;
        logic        done;
        logic [31:0] size;
        logic        perr;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_flush = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_perr = 1'b0;
        m_cnt = 32'd0;  m_size = 32'd0;
    endtask

    task automatic model_word(output logic v, output logic [31:0] d);
        v = (mq.size() >= 4) || (m_flush && mq.size() > 0);
        d = 32'd0;
        for (int j = 0; j < 4; j++) begin
            if (j < mq.size()) d[31-8*j -: 8] = mq[j];
        end
    endtask

    task automatic model_step(input logic [3:0] n, input logic [63:0] val, input logic se, input logic rdy);
        logic        v;
        logic [31:0] d;
        int          sz, popped;
        sz = mq.size();
        model_word(v, d);
        popped = (v && rdy) ? ((sz >= 4) ? 4 : sz) : 0;
        if (m_done) m_cnt = 32'd0;
        if (n > 4'd8) begin
            m_perr = 1'b1;
        end else if (m_flush) begin
            if (n != 4'd0) m_perr = 1'b1;
        end else if (n != 4'd0) begin
            if (sz + int'(n) <= DEPTH) begin
                for (int k = 0; k < int'(n); k++) mq.push_back(val[63-8*k -: 8]);
                m_cnt = m_cnt + 32'(n);
            end else begin
                m_ovf = 1'b1;
            end
        end
        repeat (popped) void'(mq.pop_front());
        if (m_done) begin
            m_done = 1'b0;
        end else if (!m_flush) begin
            if (se) m_flush = 1'b1;
        end else if (mq.size() == 0) begin
            m_flush = 1'b0;
            m_done  = 1'b1;
            m_size  = m_cnt;
        end
    endtask

    task automatic model_check(input string tag);
        logic        v;
        logic [31:0] d;
        model_word(v, d);
        check({tag, "/outputs"},
              {21'd0, bus.out_valid, (bus.out_valid ? bus.out_data : 32'd0), fill_bytes,
               slice_done, overflow, protocol_error},
              {21'd0, v, (v ? d : 32'd0), 7'(mq.size()), m_done, m_ovf, m_perr});
        check({tag, "/size"}, {32'd0, slice_size_bytes}, {32'd0, m_size});
    endtask

    // One clock: drive at the falling edge, let the DUT clock, check at the next falling edge.
    task automatic cycle(input logic [3:0] n, input logic [63:0] val, input logic se,
                         input logic rdy, input string tag);
        in_enable_byte = n;
        in_val         = val;
        slice_end      = se;
        bus.out_ready  = rdy;
        #1;
        if (bus.out_valid && rdy) got_words.push_back(bus.out_data);
        @(posedge clock);
        model_step(n, val, se, rdy);
        @(negedge clock);
        model_check(tag);
    endtask

    task automatic apply_reset();
        reset_n        = 1'b0;
        in_enable_byte = 4'd0;
        in_val         = 64'd0;
        slice_end      = 1'b0;
        bus.out_ready  = 1'b0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [63:0] val;
        logic [3:0]  n;
        logic        any_done;
        int          r;

        tbl[0]  = '{4'd4, 64'h1122334455667788, 1'b0, 1'b1, 1'b1, 32'h11223344, 7'd4, 1'b0, 32'd0,  1'b0};
        tbl[1]  = '{4'd0, 64'd0,                1'b1, 1'b1, 1'b0, 32'h0,        7'd0, 1'b0, 32'd0,  1'b0};
        tbl[2]  = '{4'd0, 64'd0,                1'b0, 1'b1, 1'b0, 32'h0,        7'd0, 1'b1, 32'd4,  1'b0};
        tbl[3]  = '{4'd0, 64'd0,                1'b0, 1'b1, 1'b0, 32'h0,        7'd0, 1'b0, 32'd4,  1'b0};
        tbl[4]  = '{4'd3, 64'hAABBCCDDEEFF0011, 1'b1, 1'b1, 1'b1, 32'hAABBCC00, 7'd3, 1'b0, 32'd4,  1'b0};
        tbl[5]  = '{4'd0, 64'd0,                1'b0, 1'b1, 1'b0, 32'h0,        7'd0, 1'b1, 32'd3,  1'b0};
        tbl[6]  = '{4'd0, 64'd0,                1'b0, 1'b1, 1'b0, 32'h0,        7'd0, 1'b0, 32'd3,  1'b0};
        tbl[7]  = '{4'd9, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'h0,        7'd0, 1'b0, 32'd3,  1'b1};
        tbl[8]  = '{4'd0, 64'd0,                1'b0, 1'b1, 1'b0, 32'h0,        7'd0, 1'b0, 32'd3,  1'b1};
        tbl[9]  = '{4'd0, 64'd0,                1'b1, 1'b1, 1'b0, 32'h0,        7'd0, 1'b0, 32'd3,  1'b1};
        tbl[10] = '{4'd2, 64'h5566778899AABBCC, 1'b0, 1'b1, 1'b0, 32'h0,        7'd0, 1'b1, 32'd0,  1'b1};
        tbl[11] = '{4'd0, 64'd0,                1'b0, 1'b1, 1'b0, 32'h0,        7'd0, 1'b0, 32'd0,  1'b1};
        tbl[12] = '{4'd3, 64'h0001020000000000, 1'b0, 1'b1, 1'b0, 32'h0,        7'd3, 1'b0, 32'd0,  1'b1};
        tbl[13] = '{4'd5, 64'h0304050607000000, 1'b0, 1'b1, 1'b1, 32'h00010203, 7'd8, 1'b0, 32'd0,  1'b1};
        tbl[14] = '{4'd2, 64'h0809000000000000, 1'b0, 1'b1, 1'b1, 32'h04050607, 7'd6, 1'b0, 32'd0,  1'b1};
        tbl[15] = '{4'd6, 64'h0A0B0C0D0E0F0000, 1'b0, 1'b1, 1'b1, 32'h08090A0B, 7'd8, 1'b0, 32'd0,  1'b1};
        tbl[16] = '{4'd0, 64'd0,                1'b1, 1'b1, 1'b1, 32'h0C0D0E0F, 7'd4, 1'b0, 32'd0,  1'b1};
        tbl[17] = '{4'd0, 64'd0,                1'b0, 1'b1, 1'b0, 32'h0,        7'd0, 1'b1, 32'd16, 1'b1};
        tbl[18] = '{4'd0, 64'd0,                1'b0, 1'b1, 1'b0, 32'h0,        7'd0, 1'b0, 32'd16, 1'b1};

        reset_n        = 1'b0;
        in_enable_byte = 4'd0;
        in_val         = 64'd0;
        slice_end      = 1'b0;
        bus.out_ready  = 1'b0;
        model_reset();
        @(negedge clock);
        apply_reset();
        check("reset_state",
              {21'd0, bus.out_valid, bus.out_data, fill_bytes, slice_done, overflow, protocol_error},
              64'd0);
        check("reset_size", {32'd0, slice_size_bytes}, 64'd0);

        // Table: word assembly, partial flush, empty slices, errors, mixed counts.
        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].n, tbl[i].val, tbl[i].se, tbl[i].rdy, "tbl_model");
            check($sformatf("tbl[%0d]", i),
                  {21'd0, bus.out_valid, (bus.out_valid ? bus.out_data : 32'd0), fill_bytes,
                   slice_done, overflow, protocol_error},
                  {21'd0, tbl[i].v, (tbl[i].v ? tbl[i].d : 32'd0), tbl[i].f,
                   tbl[i].done, 1'b0, tbl[i].perr});
            check($sformatf("tbl[%0d]_size", i), {32'd0, slice_size_bytes}, {32'd0, tbl[i].size});
        end

        // Backpressure: fill to capacity, overflow on the next write, then drain in order.
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 8; k++) val[63-8*k -: 8] = 8'(8*c + k);
            cycle(4'd8, val, 1'b0, 1'b0, "bp_fill");
        end
        check("bp_fill64", {57'd0, fill_bytes}, 64'd64);
        cycle(4'd8, 64'hDEADBEEFDEADBEEF, 1'b0, 1'b0, "bp_ovf");
        check("bp_overflow", {63'd0, overflow}, 64'd1);
        check("bp_fill_held", {57'd0, fill_bytes}, 64'd64);
        got_words.delete();
        for (int c = 0; c < 17; c++) cycle(4'd0, 64'd0, 1'b0, 1'b1, "bp_drain");
        check("bp_word_count", 64'(got_words.size()), 64'd16);
        for (int i = 0; i < 16 && i < got_words.size(); i++) begin
            check($sformatf("bp_word[%0d]", i), {32'd0, got_words[i]},
                  {32'd0, 8'(4*i), 8'(4*i + 1), 8'(4*i + 2), 8'(4*i + 3)});
        end
        check("bp_empty", {56'd0, bus.out_valid, fill_bytes}, 64'd0);

        // Reset while flushing a 2-byte tail: nothing may complete afterwards.
        apply_reset();
        cycle(4'd2, 64'hA1B2C3D4E5F60718, 1'b0, 1'b0, "rmf_wr");
        cycle(4'd0, 64'd0, 1'b1, 1'b0, "rmf_se");
        check("rmf_tail_word", {31'd0, bus.out_valid, bus.out_data}, {31'd0, 1'b1, 32'hA1B20000});
        apply_reset();
        check("rmf_after_reset", {24'd0, slice_size_bytes, bus.out_valid, fill_bytes}, 64'd0);
        any_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            cycle(4'd0, 64'd0, 1'b0, 1'b1, "rmf_idle");
            any_done = any_done | slice_done;
        end
        check("rmf_no_done", {63'd0, any_done}, 64'd0);

        // Randomized traffic against the reference model.
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 39));
            if (r < 12)      n = 4'd0;
            else if (r < 39) n = 4'($urandom_range(1, 8));
            else             n = 4'($urandom_range(9, 15));
            val = {$urandom, $urandom};
            cycle(n, val, ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
